// File: rtl/bram_stream_reader.sv
// bram_stream_reader: burst reader that walks a single-port BRAM from base_addr
// for len words and presents the data as a valid/ready stream through a
// 4-entry output FIFO. Issue is credit-limited so the FIFO can never overflow.
// Optional feature: define BRAM_STREAM_READER_LAST_EN to add the m_last port.
module bram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    input  logic [DATA_WIDTH-1:0] bram_douta,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef BRAM_STREAM_READER_LAST_EN
    ,
    output logic                  m_last
`endif
);

    localparam int unsigned CNT_W      = ADDR_WIDTH + 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned OCC_W      = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [CNT_W-1:0]      rem;
    logic                  rd_v1;
    logic                  rd_v2;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  last_xfer;
    logic [3:0]            credit;

    assign bram_wea = 1'b0;
    assign m_valid  = (occ != '0);
    assign m_data   = fifo_mem[rd_ptr];

    // Handshake, credit check and end-of-burst detection
    always_comb begin
        pop       = m_valid && m_ready;
        push      = rd_v2;
        credit    = 4'(occ) + 4'(rd_v1) + 4'(rd_v2);
        issue     = (state == RUN) && (credit < (4'(FIFO_DEPTH) + 4'(pop)));
        last_xfer = (state == DRAIN) && pop && (occ == OCC_W'(1)) && !rd_v1 && !rd_v2;
    end

    // Control FSM, address issue, read pipeline and output FIFO
    always_ff @(posedge clka) begin
        if (rsta) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            bram_addra <= '0;
            rd_addr    <= '0;
            rem        <= '0;
            rd_v1      <= 1'b0;
            rd_v2      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            rd_addr <= base_addr;
                            rem     <= len;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        bram_addra <= rd_addr;
                        rd_addr    <= rd_addr + ADDR_WIDTH'(1);
                        rem        <= rem - CNT_W'(1);
                        if (rem == CNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_xfer) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // BRAM samples the address one edge after issue; data lands one edge later
            rd_v1 <= issue;
            rd_v2 <= rd_v1;

            if (push) begin
                fifo_mem[wr_ptr] <= bram_douta;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef BRAM_STREAM_READER_LAST_EN
    logic [CNT_W-1:0] tx_left;

    assign m_last = m_valid && (tx_left == CNT_W'(1));

    // Words still to be transferred in the current burst
    always_ff @(posedge clka) begin
        if (rsta) begin
            tx_left <= '0;
        end else if ((state == IDLE) && start && (len != '0)) begin
            tx_left <= len;
        end else if (pop) begin
            tx_left <= tx_left - CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: scoreboard bench for bram_stream_reader with a BRAM
// model preloaded mem[i]=i. Expected words are queued when a burst is issued
// and a negedge monitor pops and compares on every stream transfer.
module tb_bram_stream_reader;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 512;

    logic          clka = 1'b0;
    logic          rsta;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          bram_wea;
    logic [AW-1:0] bram_addra;
    logic [DW-1:0] bram_douta;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef BRAM_STREAM_READER_LAST_EN
    logic          m_last;
`endif

    bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clka      (clka),
        .rsta      (rsta),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bram_wea  (bram_wea),
        .bram_addra(bram_addra),
        .bram_douta(bram_douta),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data)
`ifdef BRAM_STREAM_READER_LAST_EN
        ,
        .m_last    (m_last)
`endif
    );

    always #5 clka = ~clka;

    // BRAM model: one-cycle read latency
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i);
    end
    always @(posedge clka) bram_douta <= mem[bram_addra];

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q[$];
    int ready_mode = 0;
    int pidx = 0;
    int popped = 0;
    int issued = 0;
    int burst_len = 0;
    int max_lead = 0;
    int done_cnt = 0;
    logic [AW-1:0] nxt_addr = '0;
    logic stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sink ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
    always @(posedge clka) begin
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: begin
                m_ready = (pidx == 0) || (pidx == 3);
                pidx = (pidx + 1) % 4;
            end
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scoreboard compare, stall stability, done count, address lead
    always @(negedge clka) begin
        if (rsta) begin
            stall_prev = 1'b0;
        end else begin
            chk("wea", 32'(bram_wea), 32'd0);
            if (m_valid) begin
                if (stall_prev) chk("stall_stable", 32'(m_data), 32'(stall_data));
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 32'(m_data), 32'hFFFF_FFFF);
                    end else begin
                        logic [DW-1:0] e;
                        e = exp_q.pop_front();
                        chk("data", 32'(m_data), 32'(e));
`ifdef BRAM_STREAM_READER_LAST_EN
                        chk("m_last", 32'(m_last), 32'(exp_q.size() == 0));
`endif
                    end
                    popped++;
                end
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            if (done) done_cnt++;
            if (busy && issued < burst_len && bram_addra == nxt_addr) begin
                issued++;
                nxt_addr = nxt_addr + AW'(1);
                if (issued - popped > max_lead) max_lead = issued - popped;
            end
        end
    end

    // Issue one burst, track latency and completion, then check the bookkeeping
    task automatic run_burst(input int b, input int l, input int mode, input bit inject);
        int k;
        int first_k;
        int done_k;
        bit busy_seen;
        ready_mode = mode;
        for (int i = 0; i < l; i++) exp_q.push_back(DW'((b + i) % int'(DEPTH)));
        burst_len = l; issued = 0; popped = 0; max_lead = 0; done_cnt = 0;
        nxt_addr = AW'(b);
        first_k = -1; done_k = -1; busy_seen = 1'b0;
        @(posedge clka); #1;
        start = 1'b1; base_addr = AW'(b); len = (AW+1)'(l);
        @(posedge clka); #1;
        start = 1'b0;
        for (k = 0; k < 3000; k++) begin
            @(negedge clka);
            if (busy) busy_seen = 1'b1;
            if (m_valid && first_k < 0) first_k = k;
            if (done) begin
                done_k = k;
                chk("valid_at_done", 32'(m_valid), 32'd0);
                chk("busy_at_done", 32'(busy), 32'd0);
                break;
            end
            @(posedge clka); #1;
            if (inject && k == 4) begin
                start = 1'b1; base_addr = AW'($urandom_range(0, 511)); len = (AW+1)'(5);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (done_k < 0) chk("done_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clka);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        if (l == 0) begin
            chk("len0_done_lat", 32'(done_k), 32'd0);
            chk("len0_no_valid", 32'(first_k), 32'hFFFF_FFFF);
            chk("len0_busy", 32'(busy_seen), 32'd0);
        end else begin
            chk("first_valid_lat", 32'(first_k), 32'd3);
            chk("lead", 32'(max_lead <= 4), 32'd1);
            if (mode == 0) chk("throughput", 32'(done_k), 32'(3 + l));
        end
        exp_q.delete();
    endtask

    initial begin
        rsta = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
        repeat (3) @(posedge clka);
        #1 rsta = 1'b0;
        @(negedge clka);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_addr", 32'(bram_addra), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);

        run_burst(10, 4, 0, 1'b0);
        run_burst(510, 4, 0, 1'b0);
        run_burst(20, 8, 1, 1'b0);
        run_burst(33, 0, 0, 1'b0);
        run_burst(0, 3, 0, 1'b0);

        // Reset in the middle of a burst after two words
        begin
            int w;
            ready_mode = 0;
            for (int i = 0; i < 20; i++) exp_q.push_back(DW'(100 + i));
            popped = 0; burst_len = 0;
            @(posedge clka); #1;
            start = 1'b1; base_addr = AW'(100); len = (AW+1)'(20);
            @(posedge clka); #1;
            start = 1'b0;
            for (w = 0; w < 50 && popped < 2; w++) @(negedge clka);
            chk("pre_reset_words", 32'(popped), 32'd2);
            @(posedge clka); #1;
            rsta = 1'b1;
            exp_q.delete();
            done_cnt = 0;
            @(posedge clka); #1;
            rsta = 1'b0;
            @(negedge clka);
            chk("post_rst_valid", 32'(m_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_done", 32'(done), 32'd0);
            repeat (10) @(negedge clka);
            chk("post_rst_no_done", 32'(done_cnt), 32'd0);
            run_burst(0, 2, 0, 1'b0);
        end

        for (int n = 0; n < 12; n++) begin
            int b;
            int l;
            b = $urandom_range(0, 511);
            l = $urandom_range(1, 40);
            run_burst(b, l, $urandom_range(0, 2), l >= 8);
        end
        run_burst(37, 512, 2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
